uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 48 ++++
 rtl/uart_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and frame-length constants.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned UART_START_BITS           = 1;
  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_IDX_W                = 3;
  localparam int unsigned UART_MAX_STOP_BITS        = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  // Bits per frame and clk cycles per frame, counted from start-bit entry.
  function automatic int unsigned uart_frame_bits(input int unsigned parity_en,
                                                  input int unsigned stop_bits);
    return UART_START_BITS + UART_DATA_BITS + parity_en + stop_bits;
  endfunction

  function automatic int unsigned uart_frame_clks(input int unsigned clks_per_bit,
                                                  input int unsigned parity_en,
                                                  input int unsigned stop_bits);
    return uart_frame_bits(parity_en, stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the bit's final cycle.
// Shared between the TX serializer and the RX block.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q, bit_end_d;
  logic             bit_pre_end_q, bit_pre_end_d;

  // Flags are derived from the next count so they line up with the count they describe.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    bit_end_d     = (cnt_d == CNT_LAST);
    bit_pre_end_d = (cnt_d == CNT_PRE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      bit_end_q     <= 1'b0;
      bit_pre_end_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bit_end_q     <= bit_end_d;
      bit_pre_end_q <= bit_pre_end_d;
    end
  end

  assign bit_end     = bit_end_q;
  assign bit_pre_end = bit_pre_end_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pulls bytes from the upstream FIFO and serialises them as
// start / 8 data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic                  PAR_EN    = (PARITY_EN != 0);
  localparam logic                  PAR_ODD   = (PARITY_ODD != 0);
  localparam logic [UART_IDX_W-1:0] LAST_DATA = UART_IDX_W'(UART_DATA_BITS - 1);
  localparam logic [UART_IDX_W-1:0] LAST_STOP = UART_IDX_W'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [UART_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  fifo_re_q, fifo_re_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  bit_end;
  logic                  bit_pre_end;
  logic                  restart_c;
  logic                  fetch_ok_c;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart_c),
    .bit_end    (bit_end),
    .bit_pre_end(bit_pre_end)
  );

  assign fetch_ok_c = tx_en && !fifo_empty;

  // Next-state and datapath; bit_idx counts data bits, then is reused to count stop bits.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    restart_c = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fetch_ok_c) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = fifo_data;
        parity_d  = (^fifo_data) ^ PAR_ODD;
        bit_idx_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        restart_c = 1'b0;
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        restart_c = 1'b0;
        if (bit_end) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + UART_IDX_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        restart_c = 1'b0;
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        restart_c = 1'b0;
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = fetch_ok_c ? ST_FETCH : ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + UART_IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the edge entering it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    fifo_re_d = (state_d == ST_FETCH);
    busy_d    = (state_d != ST_IDLE);
    // bit_pre_end one cycle ahead lets done land in the final stop-bit cycle itself.
    done_d    = (state_q == ST_STOP) && bit_pre_end && (bit_idx_q == LAST_STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      fifo_re_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      fifo_re_q <= fifo_re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign fifo_re = fifo_re_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations driven from a byte-FIFO model,
// every cycle compared against a waveform built from the frame format.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam logic [3:0] IDLE_V = 4'b1000;  // {tx, fifo_re, busy, done}

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty [3];
  logic [7:0] fifo_data  [3];
  logic       re_w       [3];
  logic       tx_w       [3];
  logic       busy_w     [3];
  logic       done_w     [3];

  int         vectors;
  int         miscompares;
  logic [3:0] exp_q [$];
  logic [7:0] fmem [3][16];
  int         wp [3];
  int         rp [3];
  int         re_cnt [3];
  bit         pend [3];

  // dut0: no parity, 1 stop; dut1: even parity, 2 stop; dut2: odd parity, 1 stop
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_re(re_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_re(re_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
    .fifo_re(re_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_en(input int d);
    return (d != 0) ? 1 : 0;
  endfunction

  function automatic logic par_odd(input int d);
    return (d == 2);
  endfunction

  function automatic int stop_bits(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int frame_cycles(input int d);
    return (1 + 8 + par_en(d) + stop_bits(d)) * CPB;
  endfunction

  // One clock; FIFO data appears only in the cycle after a read strobe, noise otherwise.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (pend[i] && (rp[i] != wp[i])) begin
        fifo_data[i] = fmem[i][rp[i] % 16];
        rp[i]++;
        fifo_empty[i] = (rp[i] == wp[i]);
      end else begin
        fifo_data[i] = 8'($urandom);
      end
      pend[i] = 1'b0;
      if (re_w[i] === 1'b1) begin
        pend[i] = 1'b1;
        re_cnt[i]++;
      end
    end
  endtask

  task automatic push_byte(input int d, input logic [7:0] b);
    fmem[d][wp[d] % 16] = b;
    wp[d]++;
    fifo_empty[d] = 1'b0;
  endtask

  task automatic flush(input int d);
    rp[d] = wp[d];
    fifo_empty[d] = 1'b1;
  endtask

  // Expected per-cycle outputs for one byte: FETCH, LOAD, then each frame bit for CPB cycles.
  task automatic push_frame(input int d, input logic [7:0] b);
    logic bits [$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (par_en(d) != 0) bits.push_back((^b) ^ par_odd(d));
    for (int k = 0; k < stop_bits(d); k++) bits.push_back(1'b1);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1010);
    for (int j = 0; j < bits.size(); j++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_q.push_back({bits[j], 1'b0, 1'b1, (j == bits.size() - 1) && (c == CPB - 1)});
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(IDLE_V);
  endtask

  task automatic check(input int i, input logic [3:0] e, input string tag, input int idx);
    logic [3:0] o;
    o = {tx_w[i], re_w[i], busy_w[i], done_w[i]};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s dut%0d cycle %0d: observed {tx,re,busy,done}=%b expected %b", tag, i, idx, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Plays exp_q against dut d (others must stay idle); optionally drops tx_en or stops early.
  task automatic run_stream(input int d, input int drop_at, input int max_cyc, input string tag);
    int idx;
    logic [3:0] e;
    idx = 0;
    while ((exp_q.size() > 0) && (idx < max_cyc)) begin
      e = exp_q.pop_front();
      tick();
      for (int i = 0; i < 3; i++) check(i, (i == d) ? e : IDLE_V, tag, idx);
      if (idx == drop_at) tx_en = 1'b0;
      idx++;
    end
    exp_q.delete();
  endtask

  initial begin
    int         re0;
    int         d;
    int         n;
    int         j;
    int         drop_at;
    logic [7:0] rb [4];

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    tx_en       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fifo_empty[i] = 1'b1;
      fifo_data[i]  = 8'h00;
      wp[i] = 0; rp[i] = 0; re_cnt[i] = 0; pend[i] = 1'b0;
    end

    // Reset holds everything idle even with a byte waiting and tx_en high.
    tick();
    push_byte(0, 8'h55);
    tx_en = 1'b1;
    push_idle(3);
    run_stream(0, -1, 1000, "reset_hold");
    re0 = re_cnt[0];
    check_int("reset_no_re", re0, 0);

    // 0x55 single frame, first fetch right after reset release.
    rst = 1'b1;
    push_frame(0, 8'h55);
    push_idle(3);
    run_stream(0, -1, 1000, "byte_55");
    check_int("byte_55_re", re_cnt[0] - re0, 1);

    // Empty FIFO with tx_en high: nothing moves.
    re0 = re_cnt[0] + re_cnt[1] + re_cnt[2];
    push_idle(100);
    run_stream(0, -1, 1000, "empty_fifo");
    check_int("empty_fifo_re", re_cnt[0] + re_cnt[1] + re_cnt[2] - re0, 0);
    tx_en = 1'b0;

    // Back-to-back 0xA5, 0x3C with a 2-cycle gap.
    re0 = re_cnt[0];
    push_byte(0, 8'hA5);
    push_byte(0, 8'h3C);
    tx_en = 1'b1;
    push_frame(0, 8'hA5);
    push_frame(0, 8'h3C);
    push_idle(3);
    run_stream(0, -1, 1000, "b2b_a5_3c");
    check_int("b2b_re", re_cnt[0] - re0, 2);
    tx_en = 1'b0;

    // Parity of 0x07: even -> 1, odd -> 0.
    for (int k = 1; k < 3; k++) begin
      push_byte(k, 8'h07);
      tx_en = 1'b1;
      push_frame(k, 8'h07);
      push_idle(2);
      run_stream(k, -1, 1000, (k == 1) ? "parity_even_07" : "parity_odd_07");
      tx_en = 1'b0;
    end
    check_int("odd_frame_len", frame_cycles(2), 44);

    // Two stop bits, tx_en dropped during data bit 5: frame completes, no next fetch.
    re0 = re_cnt[1];
    push_byte(1, 8'hC6);
    push_byte(1, 8'h19);
    tx_en = 1'b1;
    push_frame(1, 8'hC6);
    push_idle(6);
    run_stream(1, 2 + CPB + 5 * CPB + 1, 1000, "drop_en_stop2");
    check_int("drop_en_re", re_cnt[1] - re0, 1);
    flush(1);

    // Reset during data bit 3 of 0x81; the following byte goes next, 0x81 never resent.
    re0 = re_cnt[0];
    rb[0] = 8'($urandom);
    push_byte(0, 8'h81);
    push_byte(0, rb[0]);
    tx_en = 1'b1;
    push_frame(0, 8'h81);
    run_stream(0, -1, 2 + CPB + 3 * CPB + 2, "pre_abort_81");
    rst = 1'b0;
    push_idle(1);
    run_stream(0, -1, 1000, "abort_81");
    rst = 1'b1;
    push_frame(0, rb[0]);
    push_idle(3);
    run_stream(0, -1, 1000, "after_abort");
    check_int("abort_re", re_cnt[0] - re0, 2);
    tx_en = 1'b0;

    // Random bursts, random configuration, optional mid-burst tx_en drop.
    for (int r = 0; r < 8; r++) begin
      d  = $urandom_range(0, 2);
      n  = $urandom_range(1, 4);
      j  = $urandom_range(0, n);
      drop_at = -1;
      re0 = re_cnt[d];
      for (int k = 0; k < n; k++) begin
        rb[k] = 8'($urandom);
        push_byte(d, rb[k]);
      end
      tx_en = 1'b1;
      for (int k = 0; k < n; k++) begin
        if ((j == n) || (k <= j)) push_frame(d, rb[k]);
      end
      if (j < n) drop_at = j * (frame_cycles(d) + 2) + $urandom_range(0, frame_cycles(d) + 1);
      push_idle(3);
      run_stream(d, drop_at, 1000, "random_burst");
      check_int("random_re", re_cnt[d] - re0, (j == n) ? n : j + 1);
      tx_en = 1'b0;
      flush(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
